// File: rtl/autoconfig_master.sv
// autoconfig_master
//   Zorro II AutoConfig initiator. Walks the $E8xxxx configuration chain as
//   bus master, reads each board's nibble registers, allocates a naturally
//   aligned base in the memory or I/O pool, and writes the base. A board that
//   does not fit is shut up instead.
//
// Ports
//   CLK, RESET           clock, asynchronous active-high reset
//   start                one-cycle pulse, begins a scan when idle or done
//   ADDR[23:1]           bus address, register number on ADDR[8:1]
//   AS_n, RW, DOUT       address strobe (low), 1=read/0=write, write nibble
//   DIN, DTACK           read nibble, active-high transfer acknowledge
//   busy, done, error    scan status levels
//   board_valid          one-cycle pulse per configured or shut-up board
//   board_mfg/prod/base/shut/count   details of the last reported board
module autoconfig_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_BOARDS     = 8,
  parameter logic [7:0]  MEM_BASE       = 8'h20,
  parameter logic [7:0]  MEM_LIMIT      = 8'hA0,
  parameter logic [7:0]  IO_BASE        = 8'hE9,
  parameter logic [7:0]  IO_LIMIT       = 8'hF0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  output logic [23:1] ADDR,
  output logic        AS_n,
  output logic        RW,
  output logic [3:0]  DOUT,
  input  logic [3:0]  DIN,
  input  logic        DTACK,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        board_valid,
  output logic [15:0] board_mfg,
  output logic [7:0]  board_prod,
  output logic [7:0]  board_base,
  output logic        board_shut,
  output logic [3:0]  board_count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_TYPE, S_RD_SIZE, S_RD_ID, S_ALLOC,
    S_WR_LO, S_WR_HI, S_SHUTUP, S_REPORT, S_DONE
  } state_t;

  // Bus cycle phases: LOAD puts the address/data on the bus, SETUP holds it
  // with AS_n high for a clock, STROBE waits for DTACK, RELEASE returns AS_n
  // high and acts on the result.
  typedef enum logic [1:0] {P_LOAD, P_SETUP, P_STROBE, P_RELEASE} phase_t;

  state_t        state_q;
  phase_t        ph_q;
  logic [TW-1:0] cnt_q;
  logic [3:0]    rdata_q;
  logic          to_q;
  logic          link_q;
  logic [2:0]    size_q;
  logic [23:0]   id_q;      // {prod, mfg} shifted in one nibble at a time
  logic [2:0]    idx_q;
  logic [7:0]    base_q;
  logic [8:0]    mem_ptr_q;
  logic [8:0]    io_ptr_q;

  function automatic logic [7:0] reg_of(state_t s, logic [2:0] idx);
    case (s)
      S_RD_SIZE: return 8'h01;
      S_RD_ID: begin
        case (idx)
          3'd0:    return 8'h02;
          3'd1:    return 8'h03;
          3'd2:    return 8'h08;
          3'd3:    return 8'h09;
          3'd4:    return 8'h0A;
          default: return 8'h0B;
        endcase
      end
      S_WR_LO:  return 8'h25;
      S_WR_HI:  return 8'h24;
      S_SHUTUP: return 8'h26;
      default:  return 8'h00;
    endcase
  endfunction

  // Allocation for the board whose type/size have been read.
  logic [8:0] units_d, ptr_d, limit_d, base_d, end_d;
  logic       use_mem_d, fits_d;

  always_comb begin
    units_d   = (size_q == 3'd0) ? 9'd128 : (9'd1 << (size_q - 3'd1));
    use_mem_d = link_q || (units_d > 9'd8);
    ptr_d     = use_mem_d ? mem_ptr_q : io_ptr_q;
    limit_d   = use_mem_d ? {1'b0, MEM_LIMIT} : {1'b0, IO_LIMIT};
    // The only 8M slot in Zorro II space starts at $200000, which is not 8M
    // aligned, so an 8M board is placed at the pool pointer as is.
    if (units_d == 9'd128) base_d = ptr_d;
    else                   base_d = (ptr_d + units_d - 9'd1) & ~(units_d - 9'd1);
    end_d  = base_d + units_d;
    fits_d = (end_d <= limit_d);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      ph_q        <= P_LOAD;
      cnt_q       <= '0;
      rdata_q     <= 4'h0;
      to_q        <= 1'b0;
      link_q      <= 1'b0;
      size_q      <= 3'd0;
      id_q        <= 24'h0;
      idx_q       <= 3'd0;
      base_q      <= 8'h00;
      mem_ptr_q   <= {1'b0, MEM_BASE};
      io_ptr_q    <= {1'b0, IO_BASE};
      ADDR        <= 23'h740000;
      AS_n        <= 1'b1;
      RW          <= 1'b1;
      DOUT        <= 4'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      board_valid <= 1'b0;
      board_mfg   <= 16'h0;
      board_prod  <= 8'h0;
      board_base  <= 8'h0;
      board_shut  <= 1'b0;
      board_count <= 4'h0;
    end else begin
      board_valid <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            done        <= 1'b0;
            error       <= 1'b0;
            board_count <= 4'h0;
            mem_ptr_q   <= {1'b0, MEM_BASE};
            io_ptr_q    <= {1'b0, IO_BASE};
            busy        <= 1'b1;
            ph_q        <= P_LOAD;
            state_q     <= S_RD_TYPE;
          end
        end

        S_ALLOC: begin
          ph_q <= P_LOAD;
          if (fits_d) begin
            base_q <= base_d[7:0];
            if (use_mem_d) mem_ptr_q <= end_d;
            else           io_ptr_q  <= end_d;
            state_q <= S_WR_LO;
          end else begin
            state_q <= S_SHUTUP;
          end
        end

        S_REPORT: begin
          if ({28'd0, board_count} >= MAX_BOARDS) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RD_TYPE;
          end
        end

        default: begin
          case (ph_q)
            P_LOAD: begin
              ADDR <= {8'hE8, 7'h0, reg_of(state_q, idx_q)};
              RW   <= (state_q == S_RD_TYPE) || (state_q == S_RD_SIZE) ||
                      (state_q == S_RD_ID);
              case (state_q)
                S_WR_LO: DOUT <= base_q[3:0];
                S_WR_HI: DOUT <= base_q[7:4];
                default: DOUT <= 4'h0;
              endcase
              ph_q <= P_SETUP;
            end

            P_SETUP: begin
              AS_n  <= 1'b0;
              cnt_q <= '0;
              ph_q  <= P_STROBE;
            end

            P_STROBE: begin
              if (DTACK) begin
                // Registers 0x00 and 0x01 are stored true, the rest inverted.
                rdata_q <= (ADDR[8:2] == 7'd0) ? DIN : ~DIN;
                to_q    <= 1'b0;
                AS_n    <= 1'b1;
                ph_q    <= P_RELEASE;
              end else if (cnt_q == TO_LAST) begin
                rdata_q <= 4'hF;
                to_q    <= 1'b1;
                AS_n    <= 1'b1;
                ph_q    <= P_RELEASE;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end

            P_RELEASE: begin
              ph_q <= P_LOAD;
              RW   <= 1'b1;
              // A missing board at 0x00 is the normal end of the chain.
              if (to_q && (state_q != S_RD_TYPE)) error <= 1'b1;
              case (state_q)
                S_RD_TYPE: begin
                  if (to_q || (rdata_q[3:2] != 2'b11)) begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_DONE;
                  end else begin
                    link_q  <= rdata_q[1];
                    state_q <= S_RD_SIZE;
                  end
                end
                S_RD_SIZE: begin
                  size_q  <= rdata_q[2:0];
                  idx_q   <= 3'd0;
                  state_q <= S_RD_ID;
                end
                S_RD_ID: begin
                  id_q <= {id_q[19:0], rdata_q};
                  if (idx_q == 3'd5) state_q <= S_ALLOC;
                  else               idx_q   <= idx_q + 3'd1;
                end
                S_WR_LO: state_q <= S_WR_HI;
                S_WR_HI, S_SHUTUP: begin
                  board_valid <= 1'b1;
                  board_mfg   <= id_q[15:0];
                  board_prod  <= id_q[23:16];
                  board_shut  <= (state_q == S_SHUTUP);
                  board_base  <= (state_q == S_SHUTUP) ? 8'h00 : base_q;
                  board_count <= (board_count == 4'hF) ? 4'hF : board_count + 4'd1;
                  state_q     <= S_REPORT;
                end
                default: state_q <= S_IDLE;
              endcase
            end

            default: ph_q <= P_LOAD;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_autoconfig_master.sv
module tb_autoconfig_master;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic [23:1] ADDR;
  logic        AS_n, RW;
  logic [3:0]  DOUT;
  logic [3:0]  DIN;
  logic        DTACK;
  logic        busy, done, error, board_valid, board_shut;
  logic [15:0] board_mfg;
  logic [7:0]  board_prod, board_base;
  logic [3:0]  board_count;

  int compared = 0;
  int mismatched = 0;

  autoconfig_master dut (
    .CLK(CLK), .RESET(RESET), .start(start), .ADDR(ADDR), .AS_n(AS_n),
    .RW(RW), .DOUT(DOUT), .DIN(DIN), .DTACK(DTACK), .busy(busy),
    .done(done), .error(error), .board_valid(board_valid),
    .board_mfg(board_mfg), .board_prod(board_prod), .board_base(board_base),
    .board_shut(board_shut), .board_count(board_count)
  );

  always #5 CLK = ~CLK;

  // Board chain seen by the responder. A hold register of 8'hFF means every
  // register is acknowledged.
  logic [3:0]  b_type [16];
  logic [3:0]  b_size [16];
  logic [7:0]  b_prod [16];
  logic [15:0] b_mfg  [16];
  logic [7:0]  b_hold [16];
  int nb = 0;
  int cur = 0;

  logic [11:0] wr_log [$];   // {reg, nibble}
  logic [36:0] rep_log [$];  // {mfg, prod, base, shut, count}
  int          low_runs [$];
  int          as_run = 0;
  logic        wr_seen = 1'b0;
  logic [7:0]  wr_reg = 8'h0;
  logic [3:0]  wr_dat = 4'h0;

  logic [11:0] exp_wr [$];
  logic [36:0] exp_rep [$];

  function automatic logic [3:0] raw_reg(int b, logic [7:0] r);
    case (r)
      8'h00:   return b_type[b];
      8'h01:   return b_size[b];
      8'h02:   return ~b_prod[b][7:4];
      8'h03:   return ~b_prod[b][3:0];
      8'h08:   return ~b_mfg[b][15:12];
      8'h09:   return ~b_mfg[b][11:8];
      8'h0A:   return ~b_mfg[b][7:4];
      8'h0B:   return ~b_mfg[b][3:0];
      default: return 4'h0;
    endcase
  endfunction

  always_comb begin
    DTACK = 1'b0;
    DIN   = 4'h0;
    if (!AS_n && (cur < nb)) begin
      if (ADDR[8:1] != b_hold[cur]) begin
        DTACK = 1'b1;
        DIN   = raw_reg(cur, ADDR[8:1]);
      end
    end
  end

  // Responder chain state: a completed write to 0x24 or 0x26 passes the
  // chain to the next board once AS_n is high again.
  always @(posedge CLK) begin
    if (RESET || (start && !busy)) begin
      cur     <= 0;
      wr_seen <= 1'b0;
    end else if (!AS_n && !RW) begin
      wr_seen <= 1'b1;
      wr_reg  <= ADDR[8:1];
      wr_dat  <= DOUT;
    end else if (AS_n && wr_seen) begin
      wr_log.push_back({wr_reg, wr_dat});
      if (wr_reg == 8'h24 || wr_reg == 8'h26) cur <= cur + 1;
      wr_seen <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (board_valid)
      rep_log.push_back({board_mfg, board_prod, board_base, board_shut, board_count});
    if (!AS_n) as_run <= as_run + 1;
    else if (as_run != 0) begin
      low_runs.push_back(as_run);
      as_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_board(input int i, input logic [3:0] t, input logic [3:0] s,
                           input logic [7:0] p, input logic [15:0] m, input logic [7:0] h);
    b_type[i] = t; b_size[i] = s; b_prod[i] = p; b_mfg[i] = m; b_hold[i] = h;
  endtask

  // Value the initiator should end up with for a register: the true field
  // value, or F when that register never answers.
  function automatic logic [3:0] lval(int b, logic [7:0] r);
    if (b_hold[b] == r) return 4'hF;
    case (r)
      8'h00:   return b_type[b];
      8'h01:   return b_size[b];
      8'h02:   return b_prod[b][7:4];
      8'h03:   return b_prod[b][3:0];
      8'h08:   return b_mfg[b][15:12];
      8'h09:   return b_mfg[b][11:8];
      8'h0A:   return b_mfg[b][7:4];
      8'h0B:   return b_mfg[b][3:0];
      default: return 4'h0;
    endcase
  endfunction

  task automatic run_model(output int ecnt, output bit eerr);
    int mem, io, ptr, lim, units, base;
    logic [3:0] t, s;
    logic [7:0] prod;
    logic [15:0] mfg;
    bit shut, usemem;
    mem = 32'h20; io = 32'hE9; ecnt = 0; eerr = 0;
    exp_wr.delete(); exp_rep.delete();
    for (int b = 0; b < nb; b++) begin
      if (b_hold[b] == 8'h00) break;
      t = b_type[b];
      if (t[3:2] != 2'b11) break;
      if (b_hold[b] != 8'hFF) eerr = 1;
      s = lval(b, 8'h01);
      units = (s[2:0] == 3'd0) ? 128 : (1 << (int'(s[2:0]) - 1));
      prod = {lval(b, 8'h02), lval(b, 8'h03)};
      mfg  = {lval(b, 8'h08), lval(b, 8'h09), lval(b, 8'h0A), lval(b, 8'h0B)};
      usemem = t[1] || (units > 8);
      ptr = usemem ? mem : io;
      lim = usemem ? 32'hA0 : 32'hF0;
      base = (units == 128) ? ptr : ((ptr + units - 1) / units) * units;
      shut = (base + units > lim);
      if (!shut) begin
        exp_wr.push_back({8'h25, 4'(base % 16)});
        exp_wr.push_back({8'h24, 4'(base / 16)});
        if (usemem) mem = base + units; else io = base + units;
      end else begin
        exp_wr.push_back({8'h26, 4'h0});
      end
      ecnt = (ecnt < 15) ? ecnt + 1 : 15;
      exp_rep.push_back({mfg, prod, shut ? 8'h00 : 8'(base), shut, 4'(ecnt)});
      if (ecnt >= 8) break;
    end
  endtask

  task automatic scan(input string tag, input bit poke_start);
    int w0, r0, ecnt;
    bit eerr;
    run_model(ecnt, eerr);
    w0 = wr_log.size();
    r0 = rep_log.size();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    for (int i = 0; i < 8000 && !done; i++) begin
      @(negedge CLK);
      start = (poke_start && i == 30);
    end
    start = 1'b0;
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".as_n"}, 64'(AS_n), 64'd1);
    check({tag, ".error"}, 64'(error), 64'(eerr));
    check({tag, ".count"}, 64'(board_count), 64'(ecnt));
    check({tag, ".nwr"}, 64'(wr_log.size() - w0), 64'(exp_wr.size()));
    check({tag, ".nrep"}, 64'(rep_log.size() - r0), 64'(exp_rep.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      if (w0 + i < wr_log.size()) begin
        if (exp_wr[i][11:4] == 8'h26)
          check($sformatf("%s.wr%0d", tag, i), 64'(wr_log[w0+i][11:4]), 64'h26);
        else
          check($sformatf("%s.wr%0d", tag, i), 64'(wr_log[w0+i]), 64'(exp_wr[i]));
      end
    for (int i = 0; i < exp_rep.size(); i++)
      if (r0 + i < rep_log.size())
        check($sformatf("%s.rep%0d", tag, i), 64'(rep_log[r0+i]), 64'(exp_rep[i]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, l0, mx;
    for (int i = 0; i < 16; i++) set_board(i, 4'h0, 4'h0, 8'h0, 16'h0, 8'hFF);

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst.as_n", 64'(AS_n), 64'd1);
    check("rst.addr", 64'(ADDR), 64'h740000);
    check("rst.rw", 64'(RW), 64'd1);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.outs", 64'({error, board_valid, board_shut, board_count, DOUT}), 64'd0);
    check("rst.board", 64'({board_mfg, board_prod, board_base}), 64'd0);

    // RAM 8M then IO 64K, chain ends; a stray start mid-scan is ignored
    nb = 2;
    set_board(0, 4'hE, 4'h0, 8'h11, 16'h1234, 8'hFF);
    set_board(1, 4'hC, 4'h1, 8'h22, 16'h5678, 8'hFF);
    scan("ram_io", 1'b1);
    check("ram_io.lastbase", 64'(board_base), 64'hE9);

    // IO 64K then 128K: 128K lands on the aligned pointer E A
    nb = 2;
    set_board(0, 4'hC, 4'h1, 8'h01, 16'h0101, 8'hFF);
    set_board(1, 4'hC, 4'h2, 8'h02, 16'h0202, 8'hFF);
    scan("io_aligned", 1'b0);
    check("io_aligned.base", 64'(board_base), 64'hEA);

    // IO 128K from E9 rounds to EA; next board then starts at EC
    set_board(0, 4'hC, 4'h2, 8'h03, 16'h0303, 8'hFF);
    set_board(1, 4'hC, 4'h1, 8'h04, 16'h0404, 8'hFF);
    scan("io_round", 1'b0);
    check("io_round.base", 64'(board_base), 64'hEC);

    // Two 8M memory boards: second does not fit and is shut up
    set_board(0, 4'hE, 4'h0, 8'h05, 16'h0505, 8'hFF);
    set_board(1, 4'hE, 4'h0, 8'h06, 16'h0606, 8'hFF);
    scan("two8m", 1'b0);
    check("two8m.shut", 64'({board_shut, board_base}), 64'h100);

    // ID decode: raw mfg nibbles F,8,2,4 and product nibbles B,7
    nb = 1;
    set_board(0, 4'hC, 4'h1, 8'h48, 16'h07DB, 8'hFF);
    scan("ids", 1'b0);
    check("ids.mfg", 64'(board_mfg), 64'h07DB);
    check("ids.prod", 64'(board_prod), 64'h48);

    // DTACK withheld on 0x08: timeout, error set, scan completes
    nb = 2;
    set_board(0, 4'hC, 4'h1, 8'h33, 16'h9999, 8'h08);
    set_board(1, 4'hC, 4'h1, 8'h44, 16'hAAAA, 8'hFF);
    l0 = low_runs.size();
    scan("to08", 1'b0);
    check("to08.err", 64'(error), 64'd1);
    mx = 0;
    for (int i = l0; i < low_runs.size(); i++) if (low_runs[i] > mx) mx = low_runs[i];
    check("to08.aslow", 64'((mx >= 64) && (mx <= 65)), 64'd1);

    // Reset with AS_n low mid-strobe, then a fresh scan
    set_board(0, 4'hE, 4'h0, 8'h55, 16'hBBBB, 8'hFF);
    set_board(1, 4'hC, 4'h1, 8'h66, 16'hCCCC, 8'hFF);
    w0 = wr_log.size();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    for (int i = 0; i < 500 && wr_log.size() == w0; i++) @(negedge CLK);
    for (int i = 0; i < 100 && AS_n; i++) @(negedge CLK);
    check("midrst.strobe", 64'(AS_n), 64'd0);
    RESET = 1'b1;
    #1;
    check("midrst.as_n", 64'(AS_n), 64'd1);
    check("midrst.addr", 64'(ADDR), 64'h740000);
    check("midrst.ctl", 64'({busy, done, error, board_valid, board_count, RW}), 64'd1);
    @(negedge CLK);
    @(negedge CLK) RESET = 1'b0;
    scan("midrst.rescan", 1'b0);

    // Randomized chains against the model
    for (int r = 0; r < 8; r++) begin
      nb = $urandom_range(1, 11);
      for (int i = 0; i < nb; i++) begin
        logic [3:0] t;
        logic [7:0] h;
        t = ($urandom_range(0, 9) == 0) ? 4'h8 : {2'b11, 2'($urandom)};
        h = 8'hFF;
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 7))
            0: h = 8'h00; 1: h = 8'h01; 2: h = 8'h02; 3: h = 8'h03;
            4: h = 8'h08; 5: h = 8'h09; 6: h = 8'h0A; default: h = 8'h0B;
          endcase
        end
        set_board(i, t, 4'($urandom), 8'($urandom), 16'($urandom), h);
      end
      scan($sformatf("rnd%0d", r), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
